dm_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared data memory. It sits between the pipeline M-stage memory port (port 0, "cpu") and the bridge/DMA port (port 1, "dma") on one side, and the variable-latency data memory on the other. It accepts one access at a time and arbitrates round-robin. For each access it computes the memory byte enables and the lane-shifted write data, waits for the memory acknowledge with a timeout, and returns the raw read word or an error to the winning requester.

---
 rtl/dm_arbiter.sv | 157 +++++++++++++++
 tb/tb_dm_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and sequencer between the cpu (port 0)
// and dma (port 1) requesters and the shared variable-latency data memory.
// Handles one access at a time, generates byte enables and lane-shifted
// store data, and aborts accesses that see no acknowledge within TIMEOUT cycles.
module dm_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_done,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic        dma_we,
    input  logic [1:0]  dma_size,
    input  logic [31:0] dma_wdata,
    output logic        dma_done,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner;
    logic [7:0]  cnt;

    logic        any_req;
    logic        pick;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        bad;
    logic [3:0]  ben;
    logic [31:0] lane;
    logic        timed_out;

    // Winner selection, alignment check and lane/byte-enable decode of the winner.
    always_comb begin
        any_req = cpu_req | dma_req;
        if (cpu_req && dma_req) pick = ~last_grant;
        else                    pick = dma_req;

        sel_addr  = pick ? dma_addr  : cpu_addr;
        sel_wdata = pick ? dma_wdata : cpu_wdata;
        sel_we    = pick ? dma_we    : cpu_we;
        sel_size  = pick ? dma_size  : cpu_size;

        bad  = 1'b0;
        ben  = '0;
        lane = sel_wdata;
        case (sel_size)
            2'b00: begin
                ben  = 4'b0001 << sel_addr[1:0];
                lane = {24'b0, sel_wdata[7:0]} << {sel_addr[1:0], 3'b000};
            end
            2'b01: begin
                bad  = sel_addr[0];
                ben  = sel_addr[1] ? 4'b1100 : 4'b0011;
                lane = {16'b0, sel_wdata[15:0]} << {sel_addr[1], 4'b0000};
            end
            2'b10: begin
                bad  = |sel_addr[1:0];
                ben  = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
        if (!sel_we) ben = '0;

        timed_out = (cnt == CNT_LAST);
    end

    // Next-state logic; ack in the final ACCESS cycle still counts as success.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = bad ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Grant bookkeeping, memory-side registers and response/done registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= '0;
            mem_wdata  <= '0;
            cpu_done   <= 1'b0;
            dma_done   <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant <= pick;
                        owner      <= pick;
                        cnt        <= '0;
                        if (bad) begin
                            cpu_done  <= ~pick;
                            dma_done  <= pick;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_req    <= 1'b1;
                            mem_addr   <= {sel_addr[31:2], 2'b00};
                            mem_byteen <= ben;
                            mem_wdata  <= lane;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack || timed_out) begin
                        mem_req    <= 1'b0;
                        mem_byteen <= '0;
                        cpu_done   <= ~owner;
                        dma_done   <= owner;
                        rsp_err    <= ~mem_ack;
                        rsp_rdata  <= mem_ack ? mem_rdata : '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: reset/round-robin and async-reset sequences,
// then a table of single-port accesses with hand-computed expectations.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_done;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        dma_req, dma_we, dma_done;
    logic [31:0] dma_addr, dma_wdata;
    logic [1:0]  dma_size;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;
    logic        mem_ack;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_size(cpu_size), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
        .dma_size(dma_size), .dma_wdata(dma_wdata), .dma_done(dma_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;   // ACCESS cycle index carrying the ack; 255 = never
        logic [31:0] e_addr;
        logic [3:0]  e_ben;
        logic [31:0] e_wdata;
        int          e_mreq;   // cycles mem_req is high
        int          e_done;   // cycles from request sample to done
        bit          e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for a done pulse while acking every mem_req immediately; returns {dma_done,cpu_done}.
    task automatic wait_done(output logic [31:0] who);
        who = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ack   = mem_req;
            mem_rdata = 32'h0;
            if (cpu_done || dma_done) begin
                who = {30'b0, dma_done, cpu_done};
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int mreq_cnt;
        int done_c;
        mreq_cnt = 0;
        done_c   = 0;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        if (v.port) begin
            dma_req = 1'b1; dma_we = v.we; dma_size = v.size;
            dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_size = v.size;
            cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (cpu_done || dma_done) begin
                done_c = c;
                check($sformatf("v%0d_done_port", idx), {30'b0, dma_done, cpu_done},
                      v.port ? 32'd2 : 32'd1);
                check($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.e_err});
                if (!(v.e_err && v.e_mreq == 0))
                    check($sformatf("v%0d_rdata", idx), rsp_rdata, v.e_rdata);
                check($sformatf("v%0d_resp_ben", idx), {28'b0, mem_byteen}, 32'd0);
                cpu_req = 1'b0;
                dma_req = 1'b0;
                mem_ack = 1'b0;
                break;
            end
            if (mem_req) begin
                if (mreq_cnt == 0) begin
                    check($sformatf("v%0d_addr", idx), mem_addr, v.e_addr);
                    check($sformatf("v%0d_ben", idx), {28'b0, mem_byteen}, {28'b0, v.e_ben});
                    check($sformatf("v%0d_wdata", idx), mem_wdata, v.e_wdata);
                end
                mem_ack   = (mreq_cnt == v.ack_at);
                mem_rdata = mem_ack ? v.rdata : 32'hFFFF_FFFF;
                mreq_cnt++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check($sformatf("v%0d_mreq_cycles", idx), 32'(mreq_cnt), 32'(v.e_mreq));
        check($sformatf("v%0d_done_latency", idx), 32'(done_c), 32'(v.e_done));
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), {30'b0, cpu_done, dma_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] who;
        logic        any_done;

        //            port we size   addr          wdata         rdata        ack  e_addr        e_ben    e_wdata       mreq done err e_rdata
        vecs[0]  = '{0, 1, 2'b00, 32'h0000_1003, 32'h0000_00AB, 32'hDEAD_BEEF, 0,  32'h0000_1000, 4'b1000, 32'hAB00_0000, 1, 2, 0, 32'hDEAD_BEEF};
        vecs[1]  = '{1, 0, 2'b01, 32'h0000_2006, 32'h0000_0000, 32'h1234_5678, 2,  32'h0000_2004, 4'b0000, 32'h0000_0000, 3, 4, 0, 32'h1234_5678};
        vecs[2]  = '{0, 0, 2'b10, 32'h0000_2002, 32'h0000_0000, 32'h0000_0000, 0,  32'h0,         4'b0000, 32'h0,         0, 1, 1, 32'h0};
        vecs[3]  = '{1, 1, 2'b11, 32'h0000_3000, 32'h0000_0055, 32'h0000_0000, 0,  32'h0,         4'b0000, 32'h0,         0, 1, 1, 32'h0};
        vecs[4]  = '{0, 1, 2'b01, 32'h0000_0010, 32'hFFFF_BEEF, 32'h0000_0001, 0,  32'h0000_0010, 4'b0011, 32'h0000_BEEF, 1, 2, 0, 32'h0000_0001};
        vecs[5]  = '{1, 1, 2'b01, 32'h0000_0012, 32'h1234_CAFE, 32'h0000_0002, 1,  32'h0000_0010, 4'b1100, 32'hCAFE_0000, 2, 3, 0, 32'h0000_0002};
        vecs[6]  = '{0, 1, 2'b10, 32'h0000_0044, 32'hA5A5_5A5A, 32'h0000_0003, 0,  32'h0000_0044, 4'b1111, 32'hA5A5_5A5A, 1, 2, 0, 32'h0000_0003};
        vecs[7]  = '{0, 1, 2'b00, 32'h0000_0101, 32'h0000_0077, 32'h0000_0004, 0,  32'h0000_0100, 4'b0010, 32'h0000_7700, 1, 2, 0, 32'h0000_0004};
        vecs[8]  = '{1, 1, 2'b00, 32'h0000_0102, 32'hFFFF_FF3C, 32'h0000_0005, 0,  32'h0000_0100, 4'b0100, 32'h003C_0000, 1, 2, 0, 32'h0000_0005};
        vecs[9]  = '{0, 1, 2'b01, 32'h0000_0021, 32'h0000_0001, 32'h0000_0000, 0,  32'h0,         4'b0000, 32'h0,         0, 1, 1, 32'h0};
        vecs[10] = '{0, 0, 2'b10, 32'h0000_0080, 32'h0000_0000, 32'hABCD_ABCD, 255, 32'h0000_0080, 4'b0000, 32'h0,        4, 5, 1, 32'h0};
        vecs[11] = '{1, 0, 2'b10, 32'h0000_0084, 32'h0000_0000, 32'h0BAD_F00D, 3,  32'h0000_0084, 4'b0000, 32'h0,         4, 5, 0, 32'h0BAD_F00D};
        vecs[12] = '{0, 0, 2'b00, 32'h0000_0007, 32'h0000_0000, 32'h1122_3344, 0,  32'h0000_0004, 4'b0000, 32'h0,         1, 2, 0, 32'h1122_3344};

        // Reset held with both ports requesting; all outputs must stay low.
        reset = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b10; dma_addr = 32'h4; dma_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ctl", {25'b0, mem_req, cpu_done, dma_done, rsp_err, mem_byteen}, 32'd0);
            check("reset_data", mem_addr | mem_wdata | rsp_rdata, 32'd0);
        end
        reset = 1'b1;

        // Continuous contention: cpu first, then strict alternation.
        for (int g = 0; g < 6; g++) begin
            wait_done(who);
            check($sformatf("rr_grant%0d", g), who, (g % 2 == 1) ? 32'd2 : 32'd1);
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);

        // Reset in the middle of an access drops mem_req at once and yields no done.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h40;
        @(negedge clk);
        check("mid_mreq", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1 check("async_reset", {29'b0, mem_req, cpu_done, dma_done}, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_done = any_done | cpu_done | dma_done | mem_req;
        end
        check("aborted_no_done", {31'b0, any_done}, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
